// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice: opcodes, the staged-field
// record and the canonical NOP bubble (addi x0,x0,0).
package pipe_pkg;

    // The staged record is fixed at RV32; id_ex_stage's XLEN must match this.
    localparam int PIPE_XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] NOP_OPCODE = OP_IMM;
    localparam logic [2:0] NOP_FUNCT3 = 3'b000;
    localparam logic [6:0] NOP_FUNCT7 = 7'b0000000;
    localparam logic [1:0] NOP_ALU_OP = 2'b10;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] rs1_data;
        logic [PIPE_XLEN-1:0] rs2_data;
        logic [PIPE_XLEN-1:0] imm;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [1:0]           alu_op;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
        logic                 mem_to_reg;
    } id_ex_t;

    localparam id_ex_t ID_EX_NOP = '{
        pc: '0, rs1_data: '0, rs2_data: '0, imm: '0,
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
        opcode: NOP_OPCODE, funct3: NOP_FUNCT3, funct7: NOP_FUNCT7,
        alu_op: NOP_ALU_OP,
        alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        reg_write: 1'b0, mem_to_reg: 1'b0
    };

    // U-type and JAL carry immediate bits where rs1 would sit.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the instruction in ID and a
// load sitting in EX.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (ex_rd == id_rs1) && uses_rs1(id_opcode);
    assign rs2_hit = (ex_rd == id_rs2) && uses_rs2(id_opcode);

    // x0 is never really written, so a load to x0 cannot create a hazard.
    assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
                      && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and saturating hazard counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = PIPE_XLEN,
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [6:0]       id_opcode,
    input  logic [2:0]       id_funct3,
    input  logic [6:0]       id_funct7,
    input  logic [1:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             flush,
    input  logic             ex_hold,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic [1:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_valid,
    output logic             id_stall,
    output logic [CNT_W-1:0] load_use_count,
    output logic [CNT_W-1:0] flush_count
);

    id_ex_t           id_fields;
    id_ex_t           stage_p1;
    logic             vld_p1;
    logic             load_use;
    logic [CNT_W-1:0] lu_cnt_p1;
    logic [CNT_W-1:0] fl_cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        id_fields            = ID_EX_NOP;
        id_fields.pc         = id_pc;
        id_fields.rs1_data   = id_rs1_data;
        id_fields.rs2_data   = id_rs2_data;
        id_fields.imm        = id_imm;
        id_fields.rs1        = id_rs1;
        id_fields.rs2        = id_rs2;
        id_fields.rd         = id_rd;
        id_fields.opcode     = id_opcode;
        id_fields.funct3     = id_funct3;
        id_fields.funct7     = id_funct7;
        id_fields.alu_op     = id_alu_op;
        id_fields.alu_src    = id_alu_src;
        id_fields.mem_read   = id_mem_read;
        id_fields.mem_write  = id_mem_write;
        id_fields.reg_write  = id_reg_write;
        id_fields.mem_to_reg = id_mem_to_reg;
    end

    load_use_detect u_load_use_detect (
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (vld_p1),
        .ex_mem_read (stage_p1.mem_read),
        .ex_rd       (stage_p1.rd),
        .load_use    (load_use)
    );

    // A flush kills the ID instruction anyway, so there is nothing to hold.
    assign id_stall = !reset && !flush && (ex_hold || load_use);

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_p1  <= ID_EX_NOP;
            vld_p1    <= 1'b0;
            lu_cnt_p1 <= '0;
            fl_cnt_p1 <= '0;
        end else if (flush) begin
            stage_p1  <= ID_EX_NOP;
            vld_p1    <= 1'b0;
            fl_cnt_p1 <= sat_inc(fl_cnt_p1);
        end else if (ex_hold) begin
            stage_p1  <= stage_p1;
            vld_p1    <= vld_p1;
        end else if (load_use) begin
            stage_p1  <= ID_EX_NOP;
            vld_p1    <= 1'b0;
            lu_cnt_p1 <= sat_inc(lu_cnt_p1);
        end else if (id_valid) begin
            stage_p1  <= id_fields;
            vld_p1    <= 1'b1;
        end else begin
            stage_p1  <= ID_EX_NOP;
            vld_p1    <= 1'b0;
        end
    end

    assign ex_pc          = stage_p1.pc;
    assign ex_rs1_data    = stage_p1.rs1_data;
    assign ex_rs2_data    = stage_p1.rs2_data;
    assign ex_imm         = stage_p1.imm;
    assign ex_rs1         = stage_p1.rs1;
    assign ex_rs2         = stage_p1.rs2;
    assign ex_rd          = stage_p1.rd;
    assign ex_opcode      = stage_p1.opcode;
    assign ex_funct3      = stage_p1.funct3;
    assign ex_funct7      = stage_p1.funct7;
    assign ex_alu_op      = stage_p1.alu_op;
    assign ex_alu_src     = stage_p1.alu_src;
    assign ex_mem_read    = stage_p1.mem_read;
    assign ex_mem_write   = stage_p1.mem_write;
    assign ex_reg_write   = stage_p1.reg_write;
    assign ex_mem_to_reg  = stage_p1.mem_to_reg;
    assign ex_valid       = vld_p1;
    assign load_use_count = lu_cnt_p1;
    assign flush_count    = fl_cnt_p1;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined RISC-V core; registers decoded instruction fields and operands from decode into execute.
- Feeds the EX-stage ALU controller: opcode, ALUOp, funct7, funct3.
- Owns load-use hazard detection. Inserts a NOP bubble on load-use, branch flush or invalid input. Honours a downstream EX hold.

Parameters:
XLEN, 32, datapath width of PC, operands, immediate
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  register-file read 1
id_rs2_data  in  XLEN  register-file read 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rd  in  5  destination register index
id_opcode  in  7  instr[6:0]
id_funct3  in  3  instr[14:12]
id_funct7  in  7  instr[31:25]
id_alu_op  in  2  ALUOp from main control
id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  main-control signals
flush  in  1  branch/jump taken, resolved in EX
ex_hold  in  1  EX busy; freeze this stage
ex_* (one per id_* field above)  out  same widths  registered copies
ex_valid  out  1  EX holds a valid instruction
id_stall  out  1  freeze PC and IF/ID this cycle
load_use_count  out  CNT_W  bubbles inserted for load-use
flush_count  out  CNT_W  flushes taken

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Canonical NOP (bubble), which is also the reset value:
  - opcode 0010011, funct3 000, funct7 0000000, alu_op 10;
  - rd/rs1/rs2 = 0; pc/data/imm = 0;
  - all control bits 0; ex_valid 0.
- Reset values: counters 0; id_stall 0 during reset.
- Operand use (combinational, from id_opcode):
  - uses_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL};
  - uses_rs2 = opcode in {0110011 R, 0100011 store, 1100011 branch}.
- load_use (combinational) = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((ex_rd==id_rs1 & uses_rs1) | (ex_rd==id_rs2 & uses_rs2)).
- id_stall = !flush & (ex_hold | load_use); purely combinational, same cycle.
- Per-edge priority (reset > flush > ex_hold > load_use > normal):
  - flush: load bubble; flush_count += 1 (saturating).
  - ex_hold: all ex_* and ex_valid unchanged; counters unchanged.
  - load_use: load bubble; load_use_count += 1 (saturating). Upstream holds ID, so the same instruction re-presents next cycle and no longer hazards (EX now holds the bubble).
  - normal with id_valid=1: capture every id_* field; ex_valid <= 1.
  - normal with id_valid=0: load bubble.
- Latency: exactly 1 cycle ID→EX when unstalled.
- Counters saturate at all-ones; no wrap.
- Simultaneous flush+ex_hold: flush wins; EX contents discarded.
- Simultaneous flush+load_use: flush wins; no load-use count; id_stall 0.
- Reset mid-stall or mid-hold: next state is the bubble; counters 0.
- x0 destination never causes a stall.

Decomposition:
- pipe_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - NOP field constants;
  - packed struct id_ex_t holding all staged fields, so bubble/reset is a single constant assignment.
- Sub-module: load_use_detect, combinational; inputs id opcode/rs1/rs2/valid and ex rd/mem_read/valid; output load_use.

Test Plan:
- Reset 2 cycles with random inputs → ex_valid 0, ex_opcode 0010011, ex_alu_op 10, ex_reg_write 0, both counters 0.
- add x3,x1,x2 (opcode 0110011, rs1_data 5, rs2_data 7), id_valid → next edge ex_rd 3, ex_rs1_data 5, ex_rs2_data 7, ex_funct7 0, ex_valid 1, id_stall 0.
- lw x5 in EX (mem_read 1, rd 5), ID add x6,x5,x7:
  - id_stall 1 in the same cycle;
  - next edge: EX = bubble, load_use_count 1;
  - following edge: add captured.
- lw x5 in EX with ID lui x5, then with ID addi x9,x0,1 where the load rd=0 → no stall; load_use_count stays 0.
- flush=1 during the load-use condition above → id_stall 0, EX bubble, flush_count 1, load_use_count unchanged.
- Sequence of holds and counter checks:
  - ex_hold 3 cycles → ex_* stable and id_stall 1 each cycle;
  - ex_hold+flush → bubble;
  - preload a counter to 0xFFFF via 65535 flushes, one more → stays 0xFFFF.
